cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
- Sequences one frame at a time through the three-stage streaming conv chain (stage1 -> stage2 -> stage3).
- Gates the upstream pixel stream into the chain's valid_in, counting exactly IMG_WIDTH*IMG_HEIGHT accepted pixels.
- Counts final-stage valid_out pulses, reports frame completion, and flags a drain timeout.
- The chain has no backpressure, so this block is the only flow-control point; pixel data bypasses it.

Parameters:
- IMG_WIDTH, 20, input frame width in pixels
- IMG_HEIGHT, 20, input frame height in pixels
- EXP_OUTPUTS, 9, number of final-stage valid_out pulses per frame
- TIMEOUT_CYCLES, 1024, maximum gap between final-stage results (or between last input and first result) while draining
- Derived, not overridable: NPIX = IMG_WIDTH*IMG_HEIGHT; PCW = $clog2(NPIX+1); OCW = $clog2(EXP_OUTPUTS+1); TCW = $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request; sampled in IDLE only
- abort  in  1  synchronous abort; highest priority outside IDLE
- src_valid  in  1  upstream pixel available
- src_ready  out  1  pixel accepted this cycle when src_valid && src_ready
- pipe_valid_in  out  1  drives stage1 valid_in; equals src_valid && src_ready
- pipe_valid_out  in  1  final-stage valid_out
- busy  out  1  high in FEED or DRAIN
- frame_done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky error flag; cleared by next accepted start or reset
- pix_count  out  PCW  pixels accepted in current frame
- out_count  out  OCW  results received in current frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; src_ready=0, pipe_valid_in=0, busy=0, frame_done=0, timeout_err=0, pix_count=0, out_count=0, timer=0.
- States: IDLE, FEED, DRAIN, DONE, ERR.
- IDLE:
  - src_ready=0.
  - start=1 -> FEED next cycle; clears pix_count, out_count, timer, timeout_err.
  - abort in IDLE is ignored.
- FEED:
  - src_ready=1 combinationally whenever pix_count < NPIX; pipe_valid_in is combinational from src_valid (zero added latency).
  - Each accept increments pix_count.
  - The accept that brings pix_count to NPIX moves to DRAIN next cycle; no further accepts (src_ready=0 from that edge).
- Output counting:
  - pipe_valid_out is counted in both FEED and DRAIN, because the chain emits results before input ends.
  - out_count saturates at EXP_OUTPUTS; extra pulses are ignored. No error is raised for extra pulses.
- DRAIN:
  - src_ready=0.
  - timer increments each cycle without pipe_valid_out and resets to 0 on pipe_valid_out.
  - out_count reaching EXP_OUTPUTS (including the pulse in the current cycle) -> DONE.
  - If out_count already equals EXP_OUTPUTS on entry to DRAIN, go straight to DONE on the next cycle.
  - timer reaching TIMEOUT_CYCLES -> ERR.
  - Completion takes priority over timeout in the same cycle.
- DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored (sampled next cycle in IDLE).
- ERR: timeout_err=1 (sticky), busy=0, -> IDLE next cycle.
- abort in FEED or DRAIN:
  - Next state IDLE; counters hold their values for debug.
  - No frame_done, no timeout_err.
  - src_ready drops combinationally in the abort cycle, so no pixel is accepted that cycle.
- busy is registered from state: 1 in FEED and DRAIN only.
- Counters never wrap; pix_count is capped by state logic and out_count saturates.
- Reset mid-frame: immediate return to reset values. Pipeline flushing is not this block's job; stage line buffers reset on the same rst_n.

Test Plan:
- Nominal frame, 20x20, src_valid held 1: start pulse -> exactly 400 pipe_valid_in cycles, src_ready low from cycle 401. After 9 pipe_valid_out pulses, one frame_done pulse; busy low the same cycle frame_done is high.
- Bursty source, src_valid toggling 1-0: still exactly 400 accepts, pix_count=400 at DRAIN entry, no accept while src_valid=0.
- Timeout: feed 400 pixels, inject only 5 pipe_valid_out, TIMEOUT_CYCLES=16 -> timeout_err=1 sixteen cycles after the last pulse, no frame_done, out_count=5. A following start clears timeout_err.
- Simultaneous events: 9th pipe_valid_out in the same cycle timer hits TIMEOUT_CYCLES -> frame_done pulse, timeout_err stays 0. 10th stray pulse -> out_count stays 9.
- Abort at pix_count=137 during FEED -> src_ready=0 in the abort cycle, IDLE next cycle, pix_count holds 137, no frame_done. A new start then accepts a fresh 400 pixels.
- Async reset asserted mid-DRAIN, off the clock edge -> all outputs zero immediately. start is ignored while rst_n=0, and the block runs normally after release.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the three-stage conv chain: gates exactly one frame of pixels into
// stage1, counts final-stage results, and reports completion or a drain timeout.
module cnn_frame_sequencer #(
  parameter  int IMG_WIDTH      = 20,
  parameter  int IMG_HEIGHT     = 20,
  parameter  int EXP_OUTPUTS    = 9,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int NPIX           = IMG_WIDTH * IMG_HEIGHT,
  localparam int PCW            = $clog2(NPIX + 1),
  localparam int OCW            = $clog2(EXP_OUTPUTS + 1),
  localparam int TCW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           src_valid,
  output logic           src_ready,
  output logic           pipe_valid_in,
  input  logic           pipe_valid_out,
  output logic           busy,
  output logic           frame_done,
  output logic           timeout_err,
  output logic [PCW-1:0] pix_count,
  output logic [OCW-1:0] out_count
);

  localparam logic [PCW-1:0] NPIX_C = PCW'(NPIX);
  localparam logic [OCW-1:0] EXP_C  = OCW'(EXP_OUTPUTS);
  localparam logic [TCW-1:0] TMO_C  = TCW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, DONE, ERR} state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pix_nxt;
  logic [OCW-1:0] out_nxt, out_sat;
  logic [TCW-1:0] timer, timer_nxt, timer_inc;
  logic           clear_err, set_err;

  // Results arrive while input is still streaming, so counting runs in FEED too.
  assign out_sat   = (pipe_valid_out && (out_count < EXP_C)) ? out_count + 1'b1 : out_count;
  assign timer_inc = timer + 1'b1;

  always_comb begin
    state_nxt = state;
    src_ready = 1'b0;
    pix_nxt   = pix_count;
    out_nxt   = out_count;
    timer_nxt = timer;
    clear_err = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          pix_nxt   = '0;
          out_nxt   = '0;
          timer_nxt = '0;
          clear_err = 1'b1;
        end
      end
      FEED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          src_ready = (pix_count < NPIX_C);
          out_nxt   = out_sat;
          if (src_valid && src_ready) begin
            pix_nxt = pix_count + 1'b1;
            if (pix_nxt == NPIX_C) state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          out_nxt   = out_sat;
          timer_nxt = pipe_valid_out ? '0 : timer_inc;
          // A completing pulse also restarts the timer, so it always beats the timeout.
          if (out_sat == EXP_C) begin
            state_nxt = DONE;
          end else if (!pipe_valid_out && (timer_inc == TMO_C)) begin
            state_nxt = ERR;
            set_err   = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_count   <= '0;
      out_count   <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_count <= pix_nxt;
      out_count <= out_nxt;
      timer     <= timer_nxt;
      busy      <= (state_nxt == FEED) || (state_nxt == DRAIN);
      if (clear_err)    timeout_err <= 1'b0;
      else if (set_err) timeout_err <= 1'b1;
    end
  end

  assign pipe_valid_in = src_valid && src_ready;
  assign frame_done    = (state == DONE);

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomized frame scenarios for cnn_frame_sequencer, checked cycle by cycle against a
// frame-level reference model that predicts feed end, outcome cycle and final counts.
module tb_cnn_frame_sequencer;

  localparam int W    = 20;
  localparam int H    = 20;
  localparam int NPIX = W * H;
  localparam int EXP  = 9;
  localparam int TMO  = 16;
  localparam int MAXC = 1400;
  localparam int K_NONE = 0, K_DONE = 1, K_ERR = 2, K_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, src_valid = 1'b0, pipe_valid_out = 1'b0;
  logic       src_ready, pipe_valid_in, busy, frame_done, timeout_err;
  logic [8:0] pix_count;
  logic [3:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  bit src_pat [MAXC+4];
  bit res_pat [MAXC+4];

  cnn_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .EXP_OUTPUTS(EXP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .pipe_valid_in(pipe_valid_in),
    .pipe_valid_out(pipe_valid_out), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .pix_count(pix_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: always valid, 1: alternating 1-0, 2: random with 3/4 density
  task automatic fill_src(input int mode);
    for (int c = 0; c < MAXC + 4; c++) begin
      if (mode == 0)      src_pat[c] = 1'b1;
      else if (mode == 1) src_pat[c] = (c % 2 == 0);
      else                src_pat[c] = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic int feed_end_of();
    int n = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (src_pat[c]) n++;
      if (n == NPIX) return c;
    end
    return MAXC;
  endfunction

  task automatic fill_res(input int first, input int n, input int maxgap);
    int c = first;
    for (int i = 0; i < MAXC + 4; i++) res_pat[i] = 1'b0;
    for (int i = 0; i < n && c < MAXC; i++) begin
      res_pat[c] = 1'b1;
      c += $urandom_range(1, maxgap);
    end
  endtask

  task automatic run_frame(input int abort_at, input string tag);
    int acc = 0, outs = 0, feed_end = -1, endc = -1, kind = K_NONE, last_ref = 0, obs_acc = 0;
    logic exp_rdy;
    for (int c = 0; c < MAXC && endc < 0; c++) begin
      if (c == abort_at) begin
        endc = c; kind = K_ABORT;
      end else begin
        if (res_pat[c] && outs < EXP) outs++;
        if (feed_end < 0) begin
          if (src_pat[c]) begin
            acc++;
            if (acc == NPIX) begin feed_end = c; last_ref = c; end
          end
        end else if (outs == EXP) begin
          endc = c; kind = K_DONE;
        end else if (res_pat[c]) begin
          last_ref = c;
        end else if (c - last_ref == TMO) begin
          endc = c; kind = K_ERR;
        end
      end
    end
    if (endc < 0) endc = MAXC - 1;

    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; pipe_valid_out = 1'b0; src_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, " idle_src_ready"}, src_ready, 0);
    chk({tag, " idle_busy"}, busy, 0);
    for (int c = 0; c <= endc + 2; c++) begin
      @(posedge clk); #1;
      start          = (c == endc + 1) && (kind == K_DONE || kind == K_ERR);
      abort          = (c == abort_at);
      src_valid      = src_pat[c];
      pipe_valid_out = res_pat[c];
      @(negedge clk);
      exp_rdy = (c < endc) && (feed_end < 0 || c <= feed_end);
      chk($sformatf("%s src_ready c%0d", tag, c), src_ready, exp_rdy);
      chk($sformatf("%s pipe_valid_in c%0d", tag, c), pipe_valid_in, exp_rdy && src_pat[c]);
      chk($sformatf("%s busy c%0d", tag, c), busy, c <= endc);
      chk($sformatf("%s frame_done c%0d", tag, c), frame_done, (kind == K_DONE) && (c == endc + 1));
      chk($sformatf("%s timeout_err c%0d", tag, c), timeout_err, (kind == K_ERR) && (c > endc));
      if (pipe_valid_in) obs_acc++;
    end
    start = 1'b0; abort = 1'b0; pipe_valid_out = 1'b0;
    chk({tag, " pix_count"}, pix_count, acc);
    chk({tag, " out_count"}, out_count, outs);
    chk({tag, " accepts"}, obs_acc, acc);
  endtask

  initial begin
    int fe;
    #2;
    chk("reset src_ready", src_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset pix_count", pix_count, 0);
    chk("reset out_count", out_count, 0);
    @(negedge clk); rst_n = 1'b1;

    fill_src(0); fill_res(395, EXP, 10);             run_frame(-1, "nominal");
    fill_src(1); fill_res(790, EXP, 8);              run_frame(-1, "bursty");
    fill_src(2); fe = feed_end_of();
    fill_res(fe - $urandom_range(0, 20), EXP, 12);   run_frame(-1, "random");
    fill_src(0); fill_res(397, 5, 4);                run_frame(-1, "timeout");
    fill_src(2); fe = feed_end_of();
    fill_res(fe - 3, EXP, 6);                        run_frame(-1, "after_err");

    // 9th result lands on the cycle the gap reaches the timeout, then a stray 10th
    fill_src(0); fill_res(0, 0, 1);
    for (int i = 0; i < 8; i++) res_pat[400 + i] = 1'b1;
    res_pat[407 + TMO] = 1'b1; res_pat[408 + TMO] = 1'b1;
    run_frame(-1, "simultaneous");

    fill_src(0); fill_res(10, 12, 1);                run_frame(-1, "saturate_in_feed");
    fill_src(0); fill_res(50, 3, 30);                run_frame(137, "abort_feed");
    fill_src(0); fill_res(395, EXP, 10);             run_frame(-1, "after_abort");
    fill_src(2); fe = feed_end_of();
    fill_res(fe - 2, 4, 3);                          run_frame(fe + 4, "abort_drain");

    // asynchronous reset in the middle of DRAIN, applied off the clock edge
    fill_src(0); fill_res(0, 0, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; src_valid = 1'b1;
    repeat (405) @(posedge clk);
    #3;
    chk("pre_reset busy", busy, 1);
    chk("pre_reset pix_count", pix_count, NPIX);
    rst_n = 1'b0; start = 1'b1;
    #1;
    chk("async_reset src_ready", src_ready, 0);
    chk("async_reset pipe_valid_in", pipe_valid_in, 0);
    chk("async_reset busy", busy, 0);
    chk("async_reset frame_done", frame_done, 0);
    chk("async_reset timeout_err", timeout_err, 0);
    chk("async_reset pix_count", pix_count, 0);
    chk("async_reset out_count", out_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset busy", busy, 0);
    chk("in_reset pix_count", pix_count, 0);
    start = 1'b0; src_valid = 1'b0; rst_n = 1'b1;
    fill_res(398, EXP, 9);                           run_frame(-1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
